// File: rtl/e_muldiv_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: MD opcode encodings
// and default latencies (used by the decoder, the stall controller and the unit).
package e_muldiv_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/e_muldiv_unit_md_busy_timer.sv
// Loadable down-counter producing the MD busy flag and a one-cycle done pulse
// on the cycle whose closing edge ends the operation.
module md_busy_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] n,
  output logic             busy,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= n;
      busy <= 1'b1;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1))
        busy <= 1'b0;
    end
  end

  // A clear on the final cycle wins, so the result is never committed.
  assign done = busy && (cnt == CNT_W'(1)) && !clear;

endmodule

// File: rtl/e_muldiv_unit.sv
// E-stage multiply/divide unit with HI/LO registers for the 5-stage MIPS pipeline.
// Optional feature: define MD_FLUSH_EN to add the flush input (cancels an in-flight op).
module e_muldiv_unit
  import e_muldiv_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef MD_FLUSH_EN
  input  logic        flush,
`endif
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_rdata
);

  localparam int unsigned CNT_W = $clog2(umax(MULT_CYCLES, DIV_CYCLES) + 1);

  md_op_e      op;
  logic        cancel;
  logic        is_md, is_div, is_signed, wr_hi, wr_lo;
  logic        accept, mt_ok, done;
  logic        a_neg, b_neg, b_nz;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] res_hi, res_lo;
  logic [31:0] hi_p, lo_p;
  logic        pend_wr;

  assign op = md_op_e'(md_op);

`ifdef MD_FLUSH_EN
  assign cancel = flush;
`else
  assign cancel = 1'b0;
`endif

  always_comb begin
    is_md     = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    md_rdata  = '0;
    case (op)
      MD_MULT:  begin is_md = 1'b1; is_signed = 1'b1; end
      MD_MULTU: is_md = 1'b1;
      MD_DIV:   begin is_md = 1'b1; is_div = 1'b1; is_signed = 1'b1; end
      MD_DIVU:  begin is_md = 1'b1; is_div = 1'b1; end
      MD_MFHI:  md_rdata = HI;
      MD_MFLO:  md_rdata = LO;
      MD_MTHI:  wr_hi = 1'b1;
      MD_MTLO:  wr_lo = 1'b1;
      default:  ;
    endcase
  end

  assign accept = start && is_md && !busy && !cancel;
  assign mt_ok  = !busy && !cancel;

  // Signed divide runs on magnitudes so the MIN_INT / -1 case stays well defined.
  assign a_neg = is_signed & A[31];
  assign b_neg = is_signed & B[31];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;
  assign b_nz  = (B != '0);
  assign b_div = b_nz ? b_mag : 32'd1;
  assign q_mag = a_mag / b_div;
  assign r_mag = a_mag % b_div;
  assign quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

  assign a_ext = {{32{a_neg}}, A};
  assign b_ext = {{32{b_neg}}, B};
  assign prod  = a_ext * b_ext;

  assign res_hi = is_div ? rem : prod[63:32];
  assign res_lo = is_div ? quo : prod[31:0];

  md_busy_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .clear (reset || cancel),
    .load  (accept),
    .n     (is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)),
    .busy  (busy),
    .done  (done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      HI      <= '0;
      LO      <= '0;
      hi_p    <= '0;
      lo_p    <= '0;
      pend_wr <= 1'b0;
    end else begin
      if (accept) begin
        hi_p    <= res_hi;
        lo_p    <= res_lo;
        pend_wr <= !(is_div && !b_nz);
      end else if (cancel) begin
        pend_wr <= 1'b0;
      end
      if (done && pend_wr) begin
        HI <= hi_p;
        LO <= lo_p;
      end else begin
        if (wr_hi && mt_ok) HI <= A;
        if (wr_lo && mt_ok) LO <= A;
      end
    end
  end

  a_no_issue_while_busy: assert property (
    @(posedge clk) disable iff (reset || cancel)
      !(busy && (start || wr_hi || wr_lo))
  ) else $error("e_muldiv_unit: start/mthi/mtlo issued while busy");

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Self-checking bench for e_muldiv_unit: directed vector table, hand-written
// reset/flush/mthi sequences, and randomized ops against a 64-bit arithmetic model.
module tb_e_muldiv_unit;
  import e_muldiv_unit_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  md_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO, md_rdata;
`ifdef MD_FLUSH_EN
  logic        flush;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ref_hi, ref_lo;

  typedef struct {
    md_op_e      op;
    logic [31:0] a, b, eh, el;
  } vec_t;
  vec_t vt[10];

  always #5 clk = ~clk;

  e_muldiv_unit #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .A        (A),
    .B        (B),
`ifdef MD_FLUSH_EN
    .flush    (flush),
`endif
    .busy     (busy),
    .HI       (HI),
    .LO       (LO),
    .md_rdata (md_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit integer arithmetic on the architectural rules.
  task automatic model(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, pu, qu, ru;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    eh = ref_hi;
    el = ref_lo;
    case (op)
      MD_MULT:  begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      MD_MULTU: begin pu = ua * ub; eh = pu[63:32]; el = pu[31:0]; end
      MD_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0]; end
      MD_DIVU:  if (b != 0) begin qu = ua / ub; ru = ua % ub; eh = ru[31:0]; el = qu[31:0]; end
      default:  ;
    endcase
  endtask

  task automatic do_op(input string tag, input md_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int unsigned n_exp, cnt;
    n_exp = (op == MD_DIV || op == MD_DIVU) ? DC : MC;
    @(negedge clk);
    start = 1'b1; md_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE; A = $urandom; B = $urandom;
    chk({tag, " busy after accept"}, {31'd0, busy}, 32'd1);
    chk({tag, " HI held while busy"}, HI, ref_hi);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, cnt, n_exp);
    chk({tag, " HI"}, HI, eh);
    chk({tag, " LO"}, LO, el);
    md_op = MD_MFHI; #1;
    chk({tag, " mfhi rdata"}, md_rdata, eh);
    md_op = MD_MFLO; #1;
    chk({tag, " mflo rdata"}, md_rdata, el);
    md_op = MD_NONE;
    ref_hi = eh;
    ref_lo = el;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] eh, el, b_r;
    md_op_e      rop;
    md_op_e      ops[4];

    vt[0] = '{MD_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vt[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vt[2] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3] = '{MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vt[4] = '{MD_DIV,   32'h12345678, 32'h00000000, 32'h00000001, 32'h00000003};
    vt[5] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vt[6] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vt[7] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vt[8] = '{MD_DIVU,  32'h00000000, 32'h00000000, 32'h00000001, 32'hFFFFFFFD};
    vt[9] = '{MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};

    reset = 1'b1; start = 1'b0; md_op = MD_NONE; A = '0; B = '0;
`ifdef MD_FLUSH_EN
    flush = 1'b0;
`endif
    ref_hi = '0; ref_lo = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    reset = 1'b0;
    #1;
    chk("none rdata", md_rdata, 32'd0);

    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].eh, vt[i].el);

    // mthi / mtlo: single-cycle, no busy, no same-cycle bypass to mfhi.
    @(negedge clk);
    md_op = MD_MTHI; A = 32'h00001234;
    #1;
    chk("mthi same-cycle HI", HI, ref_hi);
    @(negedge clk);
    chk("mthi busy", {31'd0, busy}, 32'd0);
    chk("mthi HI", HI, 32'h00001234);
    chk("mthi LO kept", LO, ref_lo);
    md_op = MD_MFHI; #1;
    chk("mfhi after mthi", md_rdata, 32'h00001234);
    @(negedge clk);
    md_op = MD_MTLO; A = 32'h0000CAFE;
    @(negedge clk);
    md_op = MD_MFLO; #1;
    chk("mtlo LO", LO, 32'h0000CAFE);
    chk("mflo after mtlo", md_rdata, 32'h0000CAFE);
    chk("mtlo HI kept", HI, 32'h00001234);
    md_op = MD_NONE;
    ref_hi = 32'h00001234; ref_lo = 32'h0000CAFE;

    // Reset in busy cycle 3 of a divide discards the operation.
    @(negedge clk);
    start = 1'b1; md_op = MD_DIV; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid-op reset busy", {31'd0, busy}, 32'd0);
    chk("mid-op reset HI", HI, 32'd0);
    chk("mid-op reset LO", LO, 32'd0);
    repeat (DC + 2) @(negedge clk);
    chk("mid-op reset HI stays", HI, 32'd0);
    chk("mid-op reset busy stays", {31'd0, busy}, 32'd0);
    ref_hi = '0; ref_lo = '0;

`ifdef MD_FLUSH_EN
    do_op("pre-flush", MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);
    @(negedge clk);
    start = 1'b1; md_op = MD_MULT; A = 32'hFFFFFFFF; B = 32'd9;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush HI", HI, 32'd0);
    chk("flush LO", LO, 32'd15);
    repeat (MC + 2) @(negedge clk);
    chk("flush LO stays", LO, 32'd15);
    start = 1'b1; md_op = MD_DIV; A = 32'd9; B = 32'd2; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = MD_MTHI; A = 32'hAAAA5555;
    chk("flush+start busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    flush = 1'b0; md_op = MD_NONE;
    chk("flush blocks mthi", HI, 32'd0);
    ref_hi = 32'd0; ref_lo = 32'd15;
`endif

    for (int i = 0; i < 40; i++) begin
      rop = ops[$urandom_range(0, 3)];
      case ($urandom_range(0, 7))
        0:       b_r = 32'd0;
        1:       b_r = $urandom_range(1, 9);
        2:       b_r = 32'hFFFFFFFF - $urandom_range(0, 3);
        default: b_r = $urandom;
      endcase
      A = $urandom;
      model(rop, A, b_r, eh, el);
      do_op($sformatf("rand%0d", i), rop, A, b_r, eh, el);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
